cathode_top_unit: RTL and testbench

- Registered hex-to-seven-segment cathode decoder.
- Converts one 4-bit nibble into an 8-bit cathode pattern (seven segments plus decimal point) for one digit of a multiplexed display.
- The display multiplexer instantiates eight copies, one per nibble of a 32-bit value, and routes the selected copy's pattern to the shared cathode bus.

---
 rtl/cathode_top_unit.sv | 99 +++++++++
 tb/tb_cathode_top_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cathode_top_unit.sv
// -----------------------------------------------------------------------------
// cathode_top_unit
//
// Purpose:
//   Registered hex-to-seven-segment cathode decoder for one display digit.
//   It decodes a 4-bit nibble into an 8-bit cathode pattern (segments a..g
//   plus the decimal point). The pattern is registered, so the output changes
//   exactly one Clk cycle after the input is sampled and never glitches.
//
// Parameters:
//   ACTIVE_LOW : 1 = a lit segment drives 0 (common-anode style)
//                0 = a lit segment drives 1
//
// Optional feature:
//   CATHODE_DP_EN : when this macro is defined, the dp input port exists and
//                   drives the decimal point. When it is not defined, the
//                   decimal point is always unlit.
//
// Ports:
//   Clk      in   1  system clock; all state updates on the rising edge
//   Reset    in   1  synchronous, active-low; blanks the digit
//   encoded  in   4  hex digit to display (0x0..0xF)
//   dp       in   1  decimal point request (only with CATHODE_DP_EN)
//   cathode  out  8  registered pattern, [0]=a .. [6]=g, [7]=dp
// -----------------------------------------------------------------------------
module cathode_top_unit #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] encoded,
`ifdef CATHODE_DP_EN
   input  logic       dp,
`endif
   output logic [7:0] cathode
);

   // Level driven onto every cathode line when the digit is blanked.
   localparam logic [7:0] BLANK = ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [6:0] seg_lit;   // lit segments, active-high, bit order g..a
   logic       dp_lit;    // decimal point lit request
   logic [7:0] lit_byte;  // {dp, g..a}, active-high
   logic [7:0] cathode_d;
   logic [7:0] cathode_q;

   // Lowercase b and d keep those glyphs distinct from 8 and 0.
   always_comb begin
      seg_lit = 7'h00;
      case (encoded)
         4'h0: seg_lit = 7'h3F;
         4'h1: seg_lit = 7'h06;
         4'h2: seg_lit = 7'h5B;
         4'h3: seg_lit = 7'h4F;
         4'h4: seg_lit = 7'h66;
         4'h5: seg_lit = 7'h6D;
         4'h6: seg_lit = 7'h7D;
         4'h7: seg_lit = 7'h07;
         4'h8: seg_lit = 7'h7F;
         4'h9: seg_lit = 7'h6F;
         4'hA: seg_lit = 7'h77;
         4'hB: seg_lit = 7'h7C;
         4'hC: seg_lit = 7'h39;
         4'hD: seg_lit = 7'h5E;
         4'hE: seg_lit = 7'h79;
         4'hF: seg_lit = 7'h71;
         default: seg_lit = 7'h00;
      endcase
   end

`ifdef CATHODE_DP_EN
   assign dp_lit = dp;
`else
   assign dp_lit = 1'b0;
`endif

   assign lit_byte = {dp_lit, seg_lit};

   // Polarity is applied per line: XOR with ACTIVE_LOW inverts every bit
   // for an active-low display and passes it through otherwise.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_polarity
         assign cathode_d[gi] = lit_byte[gi] ^ ACTIVE_LOW;
      end
   endgenerate

   // The reset level takes priority over the decoded value.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         cathode_q <= BLANK;
      end else begin
         cathode_q <= cathode_d;
      end
   end

   assign cathode = cathode_q;

endmodule

// File: tb/tb_cathode_top_unit.sv
// -----------------------------------------------------------------------------
// tb_cathode_top_unit
//
// Drives one active-low and one active-high instance of cathode_top_unit
// from shared stimulus and compares both outputs against hand-computed
// values. Outputs are sampled 1 time unit after the rising edge, and inputs
// are changed at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_cathode_top_unit;

   logic       Clk;
   logic       Reset;
   logic [3:0] encoded;
   logic       dp;
   logic [7:0] cathode_al;
   logic [7:0] cathode_ah;

   int total;
   int bad;

   typedef struct {
      logic [3:0] enc;
      logic [7:0] exp_al;  // expected value with ACTIVE_LOW=1
      logic [7:0] exp_ah;  // expected value with ACTIVE_LOW=0
   } vec_t;

   vec_t vecs [16];

   cathode_top_unit #(.ACTIVE_LOW(1'b1)) u_dut_al (
      .Clk     (Clk),
      .Reset   (Reset),
      .encoded (encoded),
`ifdef CATHODE_DP_EN
      .dp      (dp),
`endif
      .cathode (cathode_al)
   );

   cathode_top_unit #(.ACTIVE_LOW(1'b0)) u_dut_ah (
      .Clk     (Clk),
      .Reset   (Reset),
      .encoded (encoded),
`ifdef CATHODE_DP_EN
      .dp      (dp),
`endif
      .cathode (cathode_ah)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end else begin
         $display("ok   %s: cathode=%02h", name, act);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      dp    = 1'b0;

      vecs[0]  = '{4'h0, 8'hC0, 8'h3F};
      vecs[1]  = '{4'h1, 8'hF9, 8'h06};
      vecs[2]  = '{4'h2, 8'hA4, 8'h5B};
      vecs[3]  = '{4'h3, 8'hB0, 8'h4F};
      vecs[4]  = '{4'h4, 8'h99, 8'h66};
      vecs[5]  = '{4'h5, 8'h92, 8'h6D};
      vecs[6]  = '{4'h6, 8'h82, 8'h7D};
      vecs[7]  = '{4'h7, 8'hF8, 8'h07};
      vecs[8]  = '{4'h8, 8'h80, 8'h7F};
      vecs[9]  = '{4'h9, 8'h90, 8'h6F};
      vecs[10] = '{4'hA, 8'h88, 8'h77};
      vecs[11] = '{4'hB, 8'h83, 8'h7C};
      vecs[12] = '{4'hC, 8'hC6, 8'h39};
      vecs[13] = '{4'hD, 8'hA1, 8'h5E};
      vecs[14] = '{4'hE, 8'h86, 8'h79};
      vecs[15] = '{4'hF, 8'h8E, 8'h71};

      // Reset held for three cycles with a non-blank digit on the input.
      Reset   = 1'b0;
      encoded = 4'h8;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset_al[%0d]", i), cathode_al, 8'hFF);
         check($sformatf("reset_ah[%0d]", i), cathode_ah, 8'h00);
      end
      Reset = 1'b1;
      tick();
      check("release_al", cathode_al, 8'h80);
      check("release_ah", cathode_ah, 8'h7F);

      // Full sweep; before each edge the previous value must still be held.
      for (int i = 0; i < 16; i++) begin
         logic [7:0] prev_al;
         prev_al = (i == 0) ? 8'h80 : vecs[i-1].exp_al;
         encoded = vecs[i].enc;
         #2;
         check($sformatf("hold_before_%0h", vecs[i].enc), cathode_al, prev_al);
         tick();
         check($sformatf("sweep_al_%0h", vecs[i].enc), cathode_al, vecs[i].exp_al);
         check($sformatf("sweep_ah_%0h", vecs[i].enc), cathode_ah, vecs[i].exp_ah);
      end

      // Input change midway between edges has no effect until the next edge.
      encoded = 4'h1;
      tick();
      check("mid_first", cathode_al, 8'hF9);
      #3;
      encoded = 4'h2;
      #1;
      check("mid_hold", cathode_al, 8'hF9);
      tick();
      check("mid_next", cathode_al, 8'hA4);

      // Reset for one cycle during the stream, then decoding resumes with
      // whatever is on the input at the release edge.
      encoded = 4'h5;
      tick();
      check("mid_rst_pre", cathode_al, 8'h92);
      Reset = 1'b0;
      tick();
      check("mid_rst_al", cathode_al, 8'hFF);
      check("mid_rst_ah", cathode_ah, 8'h00);
      Reset = 1'b1;
      tick();
      check("mid_rst_resume", cathode_al, 8'h92);
      Reset   = 1'b0;
      encoded = 4'h7;
      tick();
      check("mid_rst2", cathode_al, 8'hFF);
      Reset = 1'b1;
      tick();
      check("mid_rst2_resume_al", cathode_al, 8'hF8);
      check("mid_rst2_resume_ah", cathode_ah, 8'h07);

`ifdef CATHODE_DP_EN
      encoded = 4'h0;
      dp      = 1'b1;
      tick();
      check("dp_on_al", cathode_al, 8'h40);
      check("dp_on_ah", cathode_ah, 8'hBF);
      dp = 1'b0;
      tick();
      check("dp_off_al", cathode_al, 8'hC0);
      check("dp_off_ah", cathode_ah, 8'h3F);
      dp    = 1'b1;
      Reset = 1'b0;
      tick();
      check("dp_reset_al", cathode_al, 8'hFF);
      check("dp_reset_ah", cathode_ah, 8'h00);
      Reset = 1'b1;
      dp    = 1'b0;
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
